// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged core/USB reset release behind a qualified PLL lock
module pll_reset_sequencer #(
    parameter int LOCK_STABLE = 1024,
    parameter int CORE_HOLD   = 16,
    parameter int USB_DELAY   = 48000
) (
    input  logic       clk_48mhz,
    input  logic       rst_n,
    input  logic       clk_locked,
    input  logic       soft_rst_req,
    output logic       core_rst_n,
    output logic       usb_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    // One shared counter sized for the longest of the three intervals.
    localparam int MAX_AB = (LOCK_STABLE > CORE_HOLD) ? LOCK_STABLE : CORE_HOLD;
    localparam int MAX_P  = (MAX_AB > USB_DELAY) ? MAX_AB : USB_DELAY;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CH_LAST  = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] UD_LAST  = CNT_W'(USB_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        HOLD      = 3'd2,
        STAGE     = 3'd3,
        RUN       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             lock_s;
    logic             loss_inc;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             core_rst_n_q, usb_rst_n_q, ready_q;

    // Two-flop synchroniser: the only consumer of the asynchronous lock flag.
    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= clk_locked;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    // Next-state logic; lock loss beats soft reset beats the normal count-out.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_inc = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = CNT_ZERO;
                if (lock_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == LS_LAST) begin
                    state_d = HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = CNT_ZERO;
                    loss_inc = 1'b1;
                end else if (cnt_q == CH_LAST) begin
                    state_d = STAGE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STAGE: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = CNT_ZERO;
                    loss_inc = 1'b1;
                end else if (soft_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == UD_LAST) begin
                    state_d = RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = CNT_ZERO;
                    loss_inc = 1'b1;
                end else if (soft_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Saturating lock-loss counter, only cleared by rst_n.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_inc && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // State, counter and outputs registered together so resets change on the state edge.
    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= CNT_ZERO;
            loss_cnt_q   <= 8'd0;
            core_rst_n_q <= 1'b0;
            usb_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            core_rst_n_q <= (state_d == STAGE) || (state_d == RUN);
            usb_rst_n_q  <= (state_d == RUN);
            ready_q      <= (state_d == RUN);
        end
    end

    assign core_rst_n      = core_rst_n_q;
    assign usb_rst_n       = usb_rst_n_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int LS = 4;
    localparam int CH = 2;
    localparam int UD = 3;

    logic       clk;
    logic       rst_n;
    logic       clk_locked;
    logic       soft_rst_req;
    logic       core_rst_n;
    logic       usb_rst_n;
    logic       ready;
    logic [7:0] lock_loss_count;

    pll_reset_sequencer #(
        .LOCK_STABLE(LS),
        .CORE_HOLD  (CH),
        .USB_DELAY  (UD)
    ) dut (
        .clk_48mhz      (clk),
        .rst_n          (rst_n),
        .clk_locked     (clk_locked),
        .soft_rst_req   (soft_rst_req),
        .core_rst_n     (core_rst_n),
        .usb_rst_n      (usb_rst_n),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       core;
        logic       usb;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: lock_s is the input two edges late; "qual" means the lock has
    // been seen high for LS+1 consecutive edges; "t" is edges elapsed since the hold began.
    logic m_s1, m_s2;
    bit   m_qual;
    int   m_run, m_t, m_loss;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_qual = 1'b0;
        m_run  = 0;
        m_t    = 0;
        m_loss = 0;
    endtask

    task automatic model_step(input logic lk, input logic sr);
        logic ls;
        exp_t e;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (!m_qual) begin
            if (ls) begin
                m_run++;
                if (m_run == LS + 1) begin
                    m_qual = 1'b1;
                    m_t    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!ls) begin
            m_qual = 1'b0;
            m_run  = 0;
            if (m_loss < 255) m_loss++;
        end else if (sr && m_t >= CH) begin
            m_t = 0;
        end else if (m_t < CH + UD) begin
            m_t++;
        end
        e.core = m_qual && (m_t >= CH);
        e.usb  = m_qual && (m_t >= CH + UD);
        e.rdy  = e.usb;
        e.cnt  = 8'(m_loss);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expected response against the DUT on the falling edge.
    always begin
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("core_rst_n", {7'd0, core_rst_n}, {7'd0, e.core});
            check("usb_rst_n", {7'd0, usb_rst_n}, {7'd0, e.usb});
            check("ready", {7'd0, ready}, {7'd0, e.rdy});
            check("lock_loss_count", lock_loss_count, e.cnt);
            if (usb_rst_n && !core_rst_n) begin
                check("usb_implies_core", 8'd0, 8'd1);
            end
        end
    end

    task automatic tick(input logic lk, input logic sr);
        clk_locked   = lk;
        soft_rst_req = sr;
        @(posedge clk);
        model_step(lk, sr);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_core", {7'd0, core_rst_n}, 8'd0);
        check("rst_usb", {7'd0, usb_rst_n}, 8'd0);
        check("rst_ready", {7'd0, ready}, 8'd0);
        check("rst_count", lock_loss_count, 8'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int core_e, usb_e, lost_e;

    initial begin
        rst_n        = 1'b0;
        clk_locked   = 1'b0;
        soft_rst_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_core", {7'd0, core_rst_n}, 8'd0);
        check("init_usb", {7'd0, usb_rst_n}, 8'd0);
        check("init_ready", {7'd0, ready}, 8'd0);
        check("init_count", lock_loss_count, 8'd0);
        rst_n = 1'b1;

        // Basic sequence: edge numbers of the releases.
        core_e = 0;
        usb_e  = 0;
        for (int n = 1; n <= 14; n++) begin
            tick(1'b1, 1'b0);
            if (core_rst_n && core_e == 0) core_e = n;
            if (usb_rst_n && usb_e == 0) usb_e = n;
        end
        check("core_release_edge", 8'(core_e), 8'd9);
        check("usb_release_edge", 8'(usb_e), 8'd12);

        // Lock loss in RUN, then relock.
        lost_e = 0;
        for (int n = 1; n <= 4; n++) begin
            tick((n == 1) ? 1'b0 : 1'b1, 1'b0);
            if (!ready && lost_e == 0) lost_e = n;
        end
        check("loss_ready_edge", 8'(lost_e), 8'd3);
        check("loss_count_one", lock_loss_count, 8'd1);
        repeat (16) tick(1'b1, 1'b0);
        check("relock_ready", {7'd0, ready}, 8'd1);

        // Soft reset in RUN.
        tick(1'b1, 1'b1);
        check("soft_core_low", {7'd0, core_rst_n}, 8'd0);
        tick(1'b1, 1'b0);
        check("soft_core_still_low", {7'd0, core_rst_n}, 8'd0);
        tick(1'b1, 1'b0);
        check("soft_core_rel", {7'd0, core_rst_n}, 8'd1);
        repeat (3) tick(1'b1, 1'b0);
        check("soft_usb_rel", {7'd0, usb_rst_n}, 8'd1);

        // Soft pulse during HOLD is ignored.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("hold_soft_ignored", {7'd0, core_rst_n}, 8'd1);

        // Lock loss in STAGE.
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0);
        check("stage_loss_count", lock_loss_count, 8'd2);
        repeat (16) tick(1'b1, 1'b0);

        // Acquisition glitch after a clean reset.
        do_reset();
        repeat (3) tick(1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0);
        repeat (16) tick(1'b1, 1'b0);
        check("glitch_count", lock_loss_count, 8'd0);

        // Saturation.
        for (int i = 0; i < 270; i++) begin
            repeat (8) tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        repeat (3) tick(1'b1, 1'b0);
        check("saturated", lock_loss_count, 8'd255);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 99) < 94) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
